execute_cc_stage: RTL and testbench
===================================

# execute_cc_stage

Execute-stage control and state block for the Y86-64 pipeline. Sits around the ALU:
- Upstream: decodes the E-register `icode`/`ifun` into the 2-bit ALU control.
- Downstream: consumes the ALU result and overflow, and maintains the condition-code register (ZF/SF/OF).
- Evaluates jump/cmov conditions.
- Holds the E→M pipeline register, with stall/bubble control.

## Interface
Parameters:
- `W`, 64, datapath width.
- `RNONE`, 4'hF, "no register" destination id.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `E_stat`  in  2  status; 0 AOK, 1 HLT, 2 ADR, 3 INS.
- `E_icode`  in  4  instruction code.
- `E_ifun`  in  4  function code.
- `E_valA`  in  W  operand A pass-through (store data / return address).
- `E_dstE`  in  4  ALU destination register.
- `E_dstM`  in  4  memory destination register.
- `alu_control`  out  2  to ALU; 00 add, 01 sub, 10 and, 11 xor.
- `e_valE`  in  W  ALU result.
- `e_of`  in  1  ALU overflow.
- `m_exc`  in  1  instruction in M has non-AOK status.
- `W_exc`  in  1  instruction in W has non-AOK status.
- `M_stall`  in  1  hold M register.
- `M_bubble`  in  1  load nop into M register.
- `cc`  out  3  {ZF,SF,OF}, registered.
- `e_cnd`  out  1  condition result, combinational.
- `e_dstE`  out  4  effective dstE, combinational (forwarding path).
- `M_stat` out 2, `M_icode` out 4, `M_cnd` out 1, `M_valE` out W, `M_valA` out W, `M_dstE` out 4, `M_dstM` out 4: registered outputs.

## Operation
- ALU control:
  - `E_icode`==6 (OPq): `alu_control` = `E_ifun[1:0]`.
  - All other icodes: 00 (add).
- Condition evaluation from registered `cc`:
  - Let SO = SF^OF.
  - `ifun` 0: 1; 1 (le): SO|ZF; 2 (l): SO; 3 (e): ZF; 4 (ne): !ZF; 5 (ge): !SO; 6 (g): !SO & !ZF.
  - `ifun` 7–15: 0.
- `e_cnd` is the evaluated condition when `E_icode` is 2 or 7, else 0.
- `e_dstE` = RNONE when `E_icode`==2 and `e_cnd`==0, else `E_dstE`.
- set_cc = (`E_icode`==6) & !`m_exc` & !`W_exc`.
- On set_cc the CC register loads:
  - ZF = (`e_valE`==0).
  - SF = `e_valE[W-1]`.
  - OF = `e_of`.
- Otherwise the CC register holds.
- CC update is independent of `M_stall`/`M_bubble`.
- M register, each rising edge:
  - `M_bubble`: load nop (`stat` AOK, `icode` 1, `cnd` 0, `valE`/`valA` 0, `dstE`/`dstM` RNONE).
  - else `M_stall`: hold.
  - else load {`E_stat`, `E_icode`, `e_cnd`, `e_valE`, `E_valA`, `e_dstE`, `E_dstM`}.
  - `M_bubble` has priority over `M_stall` when both are set.

## Timing
- Reset (async, `rst_n`=0): `cc` = {1,0,0}; M register holds the nop values above. Applies immediately, mid-instruction included; no partial CC update survives.
- Release is synchronous-safe: the first edge with `rst_n`=1 performs a normal update.
- `alu_control`, `e_cnd`, `e_dstE`: combinational, zero latency.
- `e_cnd` uses `cc` before the current OPq's update. An OPq immediately followed by jXX/cmov in the next cycle sees the new `cc`, because the update lands at the edge between them.
- `cc` becomes visible one cycle after the OPq occupies E.
- M outputs: one-cycle latency from E inputs.
- Exception suppression is evaluated in the same cycle as the OPq in E. `m_exc` or `W_exc` high blocks that OPq's CC write permanently; there is no retry.
- No internal state besides `cc` and the M register.

## Test plan
- Reset: `rst_n`=0 → `cc`=3'b100, `M_icode`=1, `M_dstE`=F, `M_valE`=0. Release, then `E_icode`=3, `e_valE`=5 → `M_valE`=5 after one edge.
- OPq sub with `e_valE`=0, `e_of`=0 → `alu_control`=01, `cc`=100 next cycle. Then jXX `ifun`=3 → `e_cnd`=1; `ifun`=4 → 0.
- OPq with `e_valE`=64'h8000…0, `e_of`=1 → `cc`=011. Then `ifun` 2 (l) → 0, 5 (ge) → 1, 1 (le) → 0.
- cmov `ifun`=6 with `cc`=100 and `E_dstE`=3 → `e_dstE`=F, `M_cnd`=0. Same case with `cc`=000 → `e_dstE`=3.
- OPq (`e_valE`=0) with `m_exc`=1 → `cc` unchanged (000 stays 000). Repeat with `W_exc`=1 → unchanged.
- `M_stall`=1 for 2 cycles → M outputs frozen. `M_stall`=`M_bubble`=1 → nop loaded. `rst_n` pulsed low mid-cycle → `cc`=100 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/execute_cc_if.sv
// execute_cc_if: bundles every execute-stage signal around the ALU.
//   slave  modport: the execute_cc_stage side. It takes E inputs, the ALU result and
//                   M/W control, and produces ALU control, cc, cnd, dstE and the M register.
//   master modport: the driving side (pipeline or testbench).
interface execute_cc_if #(
    parameter int W = 64
);
    logic [1:0]   E_stat;
    logic [3:0]   E_icode;
    logic [3:0]   E_ifun;
    logic [W-1:0] E_valA;
    logic [3:0]   E_dstE;
    logic [3:0]   E_dstM;
    logic [1:0]   alu_control;
    logic [W-1:0] e_valE;
    logic         e_of;
    logic         m_exc;
    logic         W_exc;
    logic         M_stall;
    logic         M_bubble;
    logic [2:0]   cc;
    logic         e_cnd;
    logic [3:0]   e_dstE;
    logic [1:0]   M_stat;
    logic [3:0]   M_icode;
    logic         M_cnd;
    logic [W-1:0] M_valE;
    logic [W-1:0] M_valA;
    logic [3:0]   M_dstE;
    logic [3:0]   M_dstM;

    modport slave (
        input  E_stat, E_icode, E_ifun, E_valA, E_dstE, E_dstM,
        input  e_valE, e_of, m_exc, W_exc, M_stall, M_bubble,
        output alu_control, cc, e_cnd, e_dstE,
        output M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM
    );

    modport master (
        output E_stat, E_icode, E_ifun, E_valA, E_dstE, E_dstM,
        output e_valE, e_of, m_exc, W_exc, M_stall, M_bubble,
        input  alu_control, cc, e_cnd, e_dstE,
        input  M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM
    );
endinterface

// File: rtl/execute_cc_stage.sv
// execute_cc_stage: Y86-64 execute-stage control and state.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset.
//   bus        : execute_cc_if.slave.
//                - E-register fields in.
//                - ALU result/overflow in.
//                - m_exc/W_exc, M_stall/M_bubble in.
//                - alu_control, cc {ZF,SF,OF}, e_cnd and e_dstE out.
//                - Registered E->M pipeline outputs.
module execute_cc_stage #(
    parameter int         W     = 64,
    parameter logic [3:0] RNONE = 4'hF
) (
    input  logic          clk,
    input  logic          rst_n,
    execute_cc_if.slave   bus
);
    localparam logic [3:0] I_NOP    = 4'd1;
    localparam logic [3:0] I_RRMOVQ = 4'd2;
    localparam logic [3:0] I_OPQ    = 4'd6;
    localparam logic [3:0] I_JXX    = 4'd7;

    typedef struct packed {
        logic [1:0]   stat;
        logic [3:0]   icode;
        logic         cnd;
        logic [W-1:0] valE;
        logic [W-1:0] valA;
        logic [3:0]   dstE;
        logic [3:0]   dstM;
    } m_reg_t;

    localparam m_reg_t M_NOP = '{stat: 2'd0, icode: I_NOP, cnd: 1'b0,
                                 valE: '0, valA: '0, dstE: RNONE, dstM: RNONE};

    logic [2:0] cc_q;
    m_reg_t     m_q;
    logic       zf, sf, of_f, so;
    logic       cond;
    logic       cnd;
    logic [3:0] dst_e;
    logic       set_cc;

    assign zf   = cc_q[2];
    assign sf   = cc_q[1];
    assign of_f = cc_q[0];
    assign so   = sf ^ of_f;

    // Condition is evaluated against the cc already committed, so an OPq
    // in E does not affect its own cycle's branch/cmov decision.
    always_comb begin
        cond = 1'b0;
        case (bus.E_ifun)
            4'd0:    cond = 1'b1;
            4'd1:    cond = so | zf;
            4'd2:    cond = so;
            4'd3:    cond = zf;
            4'd4:    cond = ~zf;
            4'd5:    cond = ~so;
            4'd6:    cond = ~so & ~zf;
            default: cond = 1'b0;
        endcase
    end

    assign cnd    = ((bus.E_icode == I_RRMOVQ) || (bus.E_icode == I_JXX)) ? cond : 1'b0;
    // A cmov that fails its condition must not write its destination.
    assign dst_e  = ((bus.E_icode == I_RRMOVQ) && !cnd) ? RNONE : bus.E_dstE;
    // An exception further down the pipe kills this OPq's flag write for good.
    assign set_cc = (bus.E_icode == I_OPQ) && !bus.m_exc && !bus.W_exc;

    assign bus.alu_control = (bus.E_icode == I_OPQ) ? bus.E_ifun[1:0] : 2'b00;
    assign bus.e_cnd       = cnd;
    assign bus.e_dstE      = dst_e;
    assign bus.cc          = cc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q <= 3'b100;
        end else if (set_cc) begin
            cc_q <= {(bus.e_valE == '0), bus.e_valE[W-1], bus.e_of};
        end
    end

    // Bubble wins over stall so a squashed instruction can never be held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q <= M_NOP;
        end else if (bus.M_bubble) begin
            m_q <= M_NOP;
        end else if (!bus.M_stall) begin
            m_q <= '{stat: bus.E_stat, icode: bus.E_icode, cnd: cnd,
                     valE: bus.e_valE, valA: bus.E_valA,
                     dstE: dst_e, dstM: bus.E_dstM};
        end
    end

    assign bus.M_stat  = m_q.stat;
    assign bus.M_icode = m_q.icode;
    assign bus.M_cnd   = m_q.cnd;
    assign bus.M_valE  = m_q.valE;
    assign bus.M_valA  = m_q.valA;
    assign bus.M_dstE  = m_q.dstE;
    assign bus.M_dstM  = m_q.dstM;
endmodule

// File: tb/tb_execute_cc_stage.sv
// tb_execute_cc_stage: directed stimulus with a scoreboard queue.
// The stimulus side drives inputs just after each rising edge and queues the
// values it expects to see. The monitor drains the queue on every falling edge,
// or on demand for the async-reset check.
module tb_execute_cc_stage;
    localparam int W = 64;

    localparam int S_ALU  = 0;
    localparam int S_CC   = 1;
    localparam int S_CND  = 2;
    localparam int S_DSTE = 3;
    localparam int S_MST  = 4;
    localparam int S_MIC  = 5;
    localparam int S_MCND = 6;
    localparam int S_MVE  = 7;
    localparam int S_MVA  = 8;
    localparam int S_MDE  = 9;
    localparam int S_MDM  = 10;

    typedef struct {
        int           sel;
        logic [W-1:0] val;
        string        name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    event chk_now;

    execute_cc_if #(.W(W)) bus ();

    execute_cc_stage #(.W(W), .RNONE(4'hF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] actual(input int sel);
        case (sel)
            S_ALU:   return W'(bus.alu_control);
            S_CC:    return W'(bus.cc);
            S_CND:   return W'(bus.e_cnd);
            S_DSTE:  return W'(bus.e_dstE);
            S_MST:   return W'(bus.M_stat);
            S_MIC:   return W'(bus.M_icode);
            S_MCND:  return W'(bus.M_cnd);
            S_MVE:   return bus.M_valE;
            S_MVA:   return bus.M_valA;
            S_MDE:   return W'(bus.M_dstE);
            default: return W'(bus.M_dstM);
        endcase
    endfunction

    // Monitor: compares everything queued so far against the live outputs.
    initial begin
        forever begin
            @(negedge clk or chk_now);
            while (sb.size() > 0) begin
                exp_t e;
                logic [W-1:0] a;
                e = sb.pop_front();
                a = actual(e.sel);
                total++;
                if (a !== e.val) begin
                    bad++;
                    $display("FAIL %s: got %0h want %0h", e.name, a, e.val);
                end
            end
        end
    end

    task automatic ex(input int sel, input logic [W-1:0] v, input string nm);
        sb.push_back('{sel, v, nm});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] ic, input logic [3:0] fn,
                          input logic [W-1:0] ve, input logic of, input logic [3:0] de);
        bus.E_icode = ic;
        bus.E_ifun  = fn;
        bus.e_valE  = ve;
        bus.e_of    = of;
        bus.E_dstE  = de;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.E_stat   = 2'd0;
        bus.E_valA   = '0;
        bus.E_dstM   = 4'hF;
        bus.m_exc    = 1'b0;
        bus.W_exc    = 1'b0;
        bus.M_stall  = 1'b0;
        bus.M_bubble = 1'b0;
        set_in(4'd1, 4'd0, '0, 1'b0, 4'hF);
        #1;
        ex(S_CC,  3'b100, "rst_cc");
        ex(S_MIC, 1,      "rst_M_icode");
        ex(S_MDE, 4'hF,   "rst_M_dstE");
        ex(S_MVE, 0,      "rst_M_valE");
        ex(S_MST, 0,      "rst_M_stat");
        @(negedge clk);
        #1 rst_n = 1'b1;

        // pass-through irmovq-style instruction
        step(); set_in(4'd3, 4'd0, 64'd5, 1'b0, 4'd2);
        ex(S_ALU, 2'b00, "alu_irmov"); ex(S_CND, 0, "cnd_irmov"); ex(S_DSTE, 2, "dstE_irmov");

        step();
        ex(S_MVE, 5, "M_valE_5"); ex(S_MIC, 3, "M_icode_3"); ex(S_MDE, 2, "M_dstE_2"); ex(S_MCND, 0, "M_cnd_0");
        set_in(4'd6, 4'd1, '0, 1'b0, 4'd4);                       // subq -> 0
        ex(S_ALU, 2'b01, "alu_sub"); ex(S_CC, 3'b100, "cc_before_sub"); ex(S_DSTE, 4, "dstE_opq");

        step();
        ex(S_CC, 3'b100, "cc_after_sub"); ex(S_MIC, 6, "M_icode_6"); ex(S_MVE, 0, "M_valE_0");
        set_in(4'd7, 4'd3, '0, 1'b0, 4'hF);                       // je
        ex(S_CND, 1, "je_zf"); ex(S_ALU, 2'b00, "alu_jxx");

        step();
        ex(S_MCND, 1, "M_cnd_je"); ex(S_MIC, 7, "M_icode_7");
        set_in(4'd7, 4'd4, '0, 1'b0, 4'hF);                       // jne
        ex(S_CND, 0, "jne_zf");

        step();
        ex(S_MCND, 0, "M_cnd_jne");
        set_in(4'd6, 4'd0, 64'h8000_0000_0000_0000, 1'b1, 4'd5); // addq, neg + overflow
        ex(S_ALU, 2'b00, "alu_add"); ex(S_CC, 3'b100, "cc_pre_add"); ex(S_CND, 0, "cnd_opq");

        step();
        ex(S_CC, 3'b011, "cc_neg_of");
        set_in(4'd7, 4'd2, '0, 1'b0, 4'hF); ex(S_CND, 0, "jl_so0");
        step(); set_in(4'd7, 4'd5, '0, 1'b0, 4'hF); ex(S_CND, 1, "jge_so0");
        step(); set_in(4'd7, 4'd1, '0, 1'b0, 4'hF); ex(S_CND, 0, "jle_so0");
        step(); set_in(4'd7, 4'd6, '0, 1'b0, 4'hF); ex(S_CND, 1, "jg_so0");
        step(); set_in(4'd7, 4'd9, '0, 1'b0, 4'hF); ex(S_CND, 0, "jxx_ifun9");

        step();
        set_in(4'd6, 4'd3, '0, 1'b0, 4'd6);                       // xorq -> 0
        ex(S_ALU, 2'b11, "alu_xor");

        step();
        ex(S_CC, 3'b100, "cc_xor_zero");
        set_in(4'd2, 4'd6, '0, 1'b0, 4'd3);                       // cmovg, fails
        ex(S_CND, 0, "cmovg_fail"); ex(S_DSTE, 4'hF, "dstE_cmov_fail");

        step();
        ex(S_MCND, 0, "M_cnd_cmov_fail"); ex(S_MDE, 4'hF, "M_dstE_cmov_fail"); ex(S_MIC, 2, "M_icode_2");
        set_in(4'd6, 4'd2, 64'd1, 1'b0, 4'd6);                    // andq -> 1
        ex(S_ALU, 2'b10, "alu_and");

        step();
        ex(S_CC, 3'b000, "cc_pos");
        set_in(4'd2, 4'd6, '0, 1'b0, 4'd3);                       // cmovg, taken
        ex(S_CND, 1, "cmovg_take"); ex(S_DSTE, 3, "dstE_cmov_take");

        step();
        ex(S_MCND, 1, "M_cnd_cmov_take"); ex(S_MDE, 3, "M_dstE_cmov_take");
        set_in(4'd6, 4'd0, '0, 1'b0, 4'd6); bus.m_exc = 1'b1;     // would set ZF

        step();
        ex(S_CC, 3'b000, "cc_m_exc_block");
        bus.m_exc = 1'b0; bus.W_exc = 1'b1;

        step();
        ex(S_CC, 3'b000, "cc_W_exc_block");
        bus.W_exc = 1'b0;
        set_in(4'd3, 4'd0, 64'h1234, 1'b0, 4'd7);
        bus.E_stat = 2'd2; bus.E_valA = 64'hABCD; bus.E_dstM = 4'd8;

        step();
        ex(S_MVE, 64'h1234, "M_valE_load"); ex(S_MVA, 64'hABCD, "M_valA_load");
        ex(S_MST, 2, "M_stat_load"); ex(S_MDM, 8, "M_dstM_load"); ex(S_MDE, 7, "M_dstE_load");
        set_in(4'd5, 4'd0, 64'h9999, 1'b0, 4'd9);
        bus.E_stat = 2'd0; bus.E_valA = 64'h7777; bus.E_dstM = 4'hA; bus.M_stall = 1'b1;

        step();
        ex(S_MVE, 64'h1234, "stall1_valE"); ex(S_MIC, 3, "stall1_icode"); ex(S_MST, 2, "stall1_stat");

        step();
        ex(S_MVE, 64'h1234, "stall2_valE"); ex(S_MDM, 8, "stall2_dstM"); ex(S_MVA, 64'hABCD, "stall2_valA");
        bus.M_bubble = 1'b1;                                       // stall+bubble together

        step();
        ex(S_MIC, 1, "bub_icode"); ex(S_MVE, 0, "bub_valE"); ex(S_MVA, 0, "bub_valA");
        ex(S_MDE, 4'hF, "bub_dstE"); ex(S_MDM, 4'hF, "bub_dstM"); ex(S_MST, 0, "bub_stat"); ex(S_MCND, 0, "bub_cnd");
        bus.M_stall = 1'b0; bus.M_bubble = 1'b0;
        set_in(4'd3, 4'd0, 64'h55, 1'b0, 4'd1);

        step();
        ex(S_MVE, 64'h55, "pre_rst_valE"); ex(S_CC, 3'b000, "pre_rst_cc");
        @(negedge clk);
        #1 rst_n = 1'b0;                                           // mid-cycle, no edge
        #1;
        ex(S_CC, 3'b100, "async_rst_cc"); ex(S_MIC, 1, "async_rst_icode"); ex(S_MVE, 0, "async_rst_valE");
        -> chk_now;
        #1 rst_n = 1'b1;

        @(negedge clk);
        @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
